// File: rtl/risc_core_mem_top.sv
// Multi-cycle 8-bit accumulator-less RISC core with 256x8 memory preloaded with a summation program.
// Latency: 3 cycles for NOP, 4 for ALU ops, 5 for RD/WR/BR/BRZ; no external backpressure (self-running).
// Backpressure: none, the core free-runs from reset until HALT.
module risc_core_mem_top #(
    parameter int WORD_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    output logic [WORD_SIZE-1:0] Reg_R0_out,
    output logic [WORD_SIZE-1:0] Reg_R1_out,
    output logic [WORD_SIZE-1:0] Reg_R2_out,
    output logic [WORD_SIZE-1:0] Reg_R3_out,
    output logic [WORD_SIZE-1:0] bus_1_out,
    input  logic                 clk,
    input  logic                 rst
);

    typedef enum logic [3:0] {
        IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_RD   = 4'h5;
    localparam logic [3:0] OP_WR   = 4'h6;
    localparam logic [3:0] OP_BR   = 4'h7;
    localparam logic [3:0] OP_BRZ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Program: load 5/1/0, loop R2+=R0, R0-=R1 until zero, store R2 at 0x83, reload into R3.
    logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH] = '{
        'h00: 8'h50, 'h01: 8'h80, 'h02: 8'h51, 'h03: 8'h81,
        'h04: 8'h52, 'h05: 8'h82, 'h06: 8'h12, 'h07: 8'h24,
        'h08: 8'h80, 'h09: 8'h0C, 'h0A: 8'h70, 'h0B: 8'h06,
        'h0C: 8'h68, 'h0D: 8'h83, 'h0E: 8'h53, 'h0F: 8'h83,
        'h10: 8'hF0, 'h80: 8'h05, 'h81: 8'h01, 'h82: 8'h00,
        default: 8'h00
    };

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [WORD_SIZE-1:0] mar_q, mar_d;
    logic [WORD_SIZE-1:0] op_q, op_d;
    logic                 z_q, z_d;
    logic [WORD_SIZE-1:0] reg_q [4];
    logic [WORD_SIZE-1:0] reg_d [4];

    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_waddr;
    logic [WORD_SIZE-1:0] mem_wdat;

    logic [3:0]           opcode;
    logic [1:0]           src;
    logic [1:0]           dest;
    logic                 is_alu;
    logic [WORD_SIZE-1:0] alu_res;
    logic [WORD_SIZE-1:0] bus_1;

    assign opcode = ir_q[7:4];
    assign src    = ir_q[3:2];
    assign dest   = ir_q[1:0];
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_NOT);

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = reg_q[src] + reg_q[dest];
            OP_SUB:  alu_res = reg_q[dest] - reg_q[src];
            OP_AND:  alu_res = reg_q[src] & reg_q[dest];
            OP_NOT:  alu_res = ~reg_q[src];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        op_d      = op_q;
        z_d       = z_q;
        for (int i = 0; i < 4; i++) begin
            reg_d[i] = reg_q[i];
        end
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdat  = '0;

        case (state_q)
            IDLE: state_d = FET1;
            FET1: begin
                mar_d   = pc_q;
                state_d = FET2;
            end
            FET2: begin
                ir_d    = mem_q[mar_q];
                pc_d    = pc_q + 1'b1;
                state_d = DEC;
            end
            DEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: state_d = EX1;
                    OP_RD:                          state_d = RD1;
                    OP_WR:                          state_d = WR1;
                    OP_BR, OP_BRZ:                  state_d = BR1;
                    OP_HALT:                        state_d = HALT;
                    default:                        state_d = FET1;
                endcase
            end
            EX1: begin
                reg_d[dest] = alu_res;
                z_d         = (alu_res == '0);
                state_d     = FET1;
            end
            // The second byte is always consumed here, so an untaken BRZ falls through past it.
            RD1, WR1, BR1: begin
                op_d = mem_q[pc_q];
                pc_d = pc_q + 1'b1;
                case (state_q)
                    RD1:     state_d = RD2;
                    WR1:     state_d = WR2;
                    default: state_d = BR2;
                endcase
            end
            RD2: begin
                reg_d[dest] = mem_q[op_q];
                state_d     = FET1;
            end
            WR2: begin
                mem_we    = 1'b1;
                mem_waddr = op_q;
                mem_wdat  = reg_q[src];
                state_d   = FET1;
            end
            BR2: begin
                if ((opcode == OP_BR) || z_q) begin
                    pc_d = op_q;
                end
                state_d = FET1;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_1 = pc_q;
        if ((((state_q == DEC) || (state_q == EX1)) && is_alu) || (state_q == WR2)) begin
            bus_1 = reg_q[src];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            mar_q   <= '0;
            op_q    <= '0;
            z_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            op_q    <= op_d;
            z_q     <= z_d;
            for (int i = 0; i < 4; i++) begin
                reg_q[i] <= reg_d[i];
            end
        end
    end

    // Memory is never cleared; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
        end
    end

    assign Reg_R0_out = reg_q[0];
    assign Reg_R1_out = reg_q[1];
    assign Reg_R2_out = reg_q[2];
    assign Reg_R3_out = reg_q[3];
    assign bus_1_out  = bus_1;

endmodule

// File: tb/tb_risc_core_mem_top.sv
// Directed bench for risc_core_mem_top: cycle-indexed expected outputs of the built-in program.
module tb_risc_core_mem_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] r0, r1, r2, r3, bus;

    risc_core_mem_top dut (
        .Reg_R0_out (r0),
        .Reg_R1_out (r1),
        .Reg_R2_out (r2),
        .Reg_R3_out (r3),
        .bus_1_out  (bus),
        .clk        (clk),
        .rst        (rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [7:0] r0, r1, r2, r3, bus;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   t_now = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        t_now++;
    endtask

    task automatic add(input int t, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.t = t; v.r0 = a; v.r1 = b; v.r2 = c; v.r3 = d; v.bus = e;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
        chk({tag, "_r0"}, r0, a);
        chk({tag, "_r1"}, r1, b);
        chk({tag, "_r2"}, r2, c);
        chk({tag, "_r3"}, r3, d);
        chk({tag, "_bus"}, bus, e);
    endtask

    task automatic run_table(input string run);
        for (int i = 0; i < vecs.size(); i++) begin
            while (t_now < vecs[i].t) step();
            chk_all($sformatf("%s_t%0d", run, vecs[i].t),
                    vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3, vecs[i].bus);
        end
    endtask

    task automatic check_halted(input string run);
        repeat (50) step();
        chk_all({run, "_halt50"}, 8'h00, 8'h01, 8'h0F, 8'h0F, 8'h11);
        chk({run, "_mem83"}, dut.mem_q[8'h83], 8'h0F);
    endtask

    initial begin
        // t = rising edges since reset release, sampled on the following falling edge.
        add(  0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add(  3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        add(  6, 8'h05, 8'h00, 8'h00, 8'h00, 8'h02);
        add(  7, 8'h05, 8'h00, 8'h00, 8'h00, 8'h02);
        add( 11, 8'h05, 8'h01, 8'h00, 8'h00, 8'h04);
        add( 16, 8'h05, 8'h01, 8'h00, 8'h00, 8'h06);
        add( 18, 8'h05, 8'h01, 8'h00, 8'h00, 8'h05);  // DEC of ADD: bus shows R0
        add( 20, 8'h05, 8'h01, 8'h05, 8'h00, 8'h07);
        add( 22, 8'h05, 8'h01, 8'h05, 8'h00, 8'h01);  // DEC of SUB: bus shows R1
        add( 24, 8'h04, 8'h01, 8'h05, 8'h00, 8'h08);
        add( 29, 8'h04, 8'h01, 8'h05, 8'h00, 8'h0A);  // BRZ falls through
        add( 34, 8'h04, 8'h01, 8'h05, 8'h00, 8'h06);
        add( 38, 8'h04, 8'h01, 8'h09, 8'h00, 8'h07);
        add( 42, 8'h03, 8'h01, 8'h09, 8'h00, 8'h08);
        add( 47, 8'h03, 8'h01, 8'h09, 8'h00, 8'h0A);
        add( 74, 8'h02, 8'h01, 8'h0E, 8'h00, 8'h07);
        add( 78, 8'h01, 8'h01, 8'h0E, 8'h00, 8'h08);
        add( 83, 8'h01, 8'h01, 8'h0E, 8'h00, 8'h0A);
        add( 92, 8'h01, 8'h01, 8'h0F, 8'h00, 8'h07);
        add( 96, 8'h00, 8'h01, 8'h0F, 8'h00, 8'h08);
        add(101, 8'h00, 8'h01, 8'h0F, 8'h00, 8'h0C);  // BRZ taken on the fifth pass
        add(105, 8'h00, 8'h01, 8'h0F, 8'h00, 8'h0F);  // WR2: bus shows R2
        add(106, 8'h00, 8'h01, 8'h0F, 8'h00, 8'h0E);
        add(111, 8'h00, 8'h01, 8'h0F, 8'h0F, 8'h10);
        add(114, 8'h00, 8'h01, 8'h0F, 8'h0F, 8'h11);

        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        t_now = 0;
        run_table("run1");
        check_halted("run1");

        // Mid-loop reset pulse, then the program must rerun identically.
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        t_now = 0;
        while (t_now < 40) step();
        chk("pre_pulse_r2", r2, 8'h09);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all("pulse", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        t_now = 0;
        run_table("run2");
        check_halted("run2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
